// File: rtl/seg7_rx_checker.sv
// Receive-side 7-segment checker: synchronises and debounces a segment pattern,
// decodes it to a hex digit and flags illegal patterns and +1 mod 16 sequence breaks.
module seg7_rx_checker #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       clear_errs,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       digit_strobe,
    output logic       pattern_err,
    output logic       seq_err,
    output logic [7:0] err_count
);

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0] sync1;
    logic [6:0] sync2;
    logic [6:0] acc_pat;
    logic [7:0] stab_cnt;
    logic       have_ref;
    logic [3:0] last_ref;

    logic       dec_legal;
    logic [3:0] dec_digit;
    logic       is_blank;
    logic       accept;
    logic [3:0] ref_next;
    logic       pat_ev;
    logic       seq_ev;

    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'h0;
        case (sync1)
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    // A pattern is accepted once, on the cycle it has been stable long enough,
    // and only if it differs from the last accepted one.
    always_comb begin
        is_blank = (sync1 == 7'h00);
        accept   = (stab_cnt == STAB_LAST) && (sync1 == sync2) && (sync1 != acc_pat);
        ref_next = last_ref + 4'd1;
        pat_ev   = accept && !is_blank && !dec_legal;
        seq_ev   = accept && dec_legal && have_ref && (dec_digit != ref_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1        <= 7'h00;
            sync2        <= 7'h00;
            stab_cnt     <= 8'd0;
            acc_pat      <= 7'h00;
            have_ref     <= 1'b0;
            last_ref     <= 4'h0;
            digit        <= 4'h0;
            digit_valid  <= 1'b0;
            digit_strobe <= 1'b0;
            pattern_err  <= 1'b0;
            seq_err      <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            sync1 <= seg_in;
            sync2 <= sync1;

            if (sync1 != sync2) begin
                stab_cnt <= 8'd0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end

            digit_strobe <= accept && dec_legal;
            pattern_err  <= pat_ev;
            seq_err      <= seq_ev;

            if (accept) begin
                acc_pat <= sync1;
                if (dec_legal) begin
                    digit       <= dec_digit;
                    digit_valid <= 1'b1;
                    last_ref    <= dec_digit;
                    have_ref    <= 1'b1;
                end else begin
                    // Blank and illegal both break the reference chain.
                    digit_valid <= 1'b0;
                    have_ref    <= 1'b0;
                end
            end

            if (clear_errs) begin
                err_count <= 8'd0;
            end else if ((pat_ev || seq_ev) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx_checker.sv
// Bench for seg7_rx_checker: a behavioural model pushes expected pulse events
// into a queue; a negedge monitor pops and compares them as the DUT reports.
module tb_seg7_rx_checker;

    localparam int STABLE = 4;
    localparam int W = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       clear_errs = 1'b0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_strobe;
    logic       pattern_err;
    logic       seq_err;
    logic [7:0] err_count;

    seg7_rx_checker #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .clear_errs(clear_errs),
        .digit(digit),
        .digit_valid(digit_valid),
        .digit_strobe(digit_strobe),
        .pattern_err(pattern_err),
        .seq_err(seq_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strobes = 0;
    logic [W-1:0] exp_q[$];

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [6:0] m_acc_pat;
    logic       m_have_ref;
    logic [3:0] m_last_ref;
    logic [3:0] m_digit;
    logic       m_valid;
    logic [7:0] m_errs;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_acc_pat = 7'h00; m_have_ref = 1'b0; m_last_ref = 4'h0;
        m_digit = 4'h0; m_valid = 1'b0; m_errs = 8'd0;
    endtask

    // Event word: {pattern_err, seq_err, digit_strobe, digit}
    task automatic model_accept(input logic [6:0] p);
        int idx;
        logic [3:0] d;
        logic [3:0] want;
        logic bad;
        idx = lookup(p);
        m_acc_pat = p;
        if (p == 7'h00) begin
            m_valid = 1'b0;
            m_have_ref = 1'b0;
        end else if (idx >= 0) begin
            d = 4'(idx);
            want = m_last_ref + 4'd1;
            bad = m_have_ref && (d != want);
            if (bad && m_errs != 8'hFF) m_errs = m_errs + 8'd1;
            m_digit = d;
            m_valid = 1'b1;
            m_last_ref = d;
            m_have_ref = 1'b1;
            exp_q.push_back({1'b0, bad, 1'b1, d});
        end else begin
            m_valid = 1'b0;
            m_have_ref = 1'b0;
            if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
            exp_q.push_back({1'b1, 1'b0, 1'b0, m_digit});
        end
    endtask

    // Called at a negedge; holds p on seg_in for n cycles.
    task automatic apply_pattern(input logic [6:0] p, input int n);
        seg_in = p;
        if (n >= STABLE + 1 && p != m_acc_pat) model_accept(p);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (rst_n && (digit_strobe || pattern_err || seq_err)) begin
            got = {pattern_err, seq_err, digit_strobe, digit};
            checks++;
            if (digit_strobe) n_strobes++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got=%h required=none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL pulse_event got=%h required=%h", got, exp);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        seg_in = 7'h00;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({digit, digit_valid, digit_strobe, pattern_err, seq_err, err_count} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0",
                     {digit, digit_valid, digit_strobe, pattern_err, seq_err, err_count});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_digit();
        seg_in = 7'h3F;
        model_accept(7'h3F);
        repeat (STABLE + 1) @(negedge clk);
        checks++;
        if (digit_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_accept valid=%b required=0", digit_valid);
        end
        @(negedge clk);
        checks++;
        if ({digit, digit_valid, err_count} !== {4'h0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL first_digit got=%h/%b/%0d required=0/1/0", digit, digit_valid, err_count);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (n_strobes !== 1) begin
            errors++;
            $display("FAIL hold_no_restrobe strobes=%0d required=1", n_strobes);
        end
    endtask

    task automatic test_count_sequence();
        for (int i = 1; i < 16; i++) apply_pattern(seg_tab[i], 10);
        apply_pattern(seg_tab[0], 10);
        drain();
        checks++;
        if ({n_strobes, digit, err_count} !== {32'd17, 4'h0, 8'd0}) begin
            errors++;
            $display("FAIL count_sequence strobes=%0d digit=%h errs=%0d required=17/0/0",
                     n_strobes, digit, err_count);
        end
    endtask

    task automatic test_seq_error();
        apply_pattern(7'h06, 10);
        apply_pattern(7'h4F, 10);
        checks++;
        if ({digit, err_count} !== {4'h3, 8'd1}) begin
            errors++;
            $display("FAIL seq_error digit=%h errs=%0d required=3/1", digit, err_count);
        end
        apply_pattern(7'h66, 10);
        checks++;
        if ({digit, err_count} !== {4'h4, 8'd1}) begin
            errors++;
            $display("FAIL seq_resume digit=%h errs=%0d required=4/1", digit, err_count);
        end
    endtask

    task automatic test_pattern_error();
        apply_pattern(7'h55, 10);
        checks++;
        if ({digit, digit_valid, err_count} !== {4'h4, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL pattern_error digit=%h valid=%b errs=%0d required=4/0/2",
                     digit, digit_valid, err_count);
        end
        apply_pattern(7'h3F, 10);
        checks++;
        if ({digit, digit_valid, err_count} !== {4'h0, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL after_illegal digit=%h valid=%b errs=%0d required=0/1/2",
                     digit, digit_valid, err_count);
        end
    endtask

    task automatic test_glitch();
        int s0;
        apply_pattern(7'h06, 10);
        drain();
        s0 = n_strobes;
        apply_pattern(7'h07, 3);
        apply_pattern(7'h06, 10);
        checks++;
        if ({n_strobes - s0, digit, err_count} !== {32'd0, 4'h1, 8'd2}) begin
            errors++;
            $display("FAIL glitch strobes=%0d digit=%h errs=%0d required=0/1/2",
                     n_strobes - s0, digit, err_count);
        end
    endtask

    task automatic test_saturation();
        int k = 0;
        for (int i = 0; i < 150; i++) begin
            apply_pattern((i % 2 == 0) ? 7'h55 : 7'h49, 8);
            apply_pattern(seg_tab[k], 8);
            apply_pattern(seg_tab[(k + 2) % 16], 8);
            k = (k + 5) % 16;
        end
        drain();
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation errs=%0d required=255", err_count);
        end
    endtask

    task automatic test_clear_collision();
        seg_in = 7'h55;
        model_accept(7'h55);
        m_errs = 8'd0;
        repeat (STABLE + 1) @(negedge clk);
        clear_errs = 1'b1;
        @(negedge clk);
        clear_errs = 1'b0;
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_collision errs=%0d required=0", err_count);
        end
        repeat (4) @(negedge clk);
        apply_pattern(7'h3F, 10);
        apply_pattern(7'h5B, 10);
        checks++;
        if (err_count !== 8'd1) begin
            errors++;
            $display("FAIL count_after_clear errs=%0d required=1", err_count);
        end
    endtask

    task automatic test_reset_mid_debounce();
        drain();
        seg_in = 7'h5B;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({digit, digit_valid, digit_strobe, pattern_err, seq_err, err_count} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h required=0",
                     {digit, digit_valid, digit_strobe, pattern_err, seq_err, err_count});
        end
        model_reset();
        rst_n = 1'b1;
        model_accept(7'h5B);
        repeat (STABLE + 1) @(negedge clk);
        checks++;
        if (digit_valid !== 1'b0) begin
            errors++;
            $display("FAIL reaccept_early valid=%b required=0", digit_valid);
        end
        @(negedge clk);
        checks++;
        if ({digit, digit_valid, err_count} !== {4'h2, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reaccept digit=%h valid=%b errs=%0d required=2/1/0",
                     digit, digit_valid, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_digit();
        test_count_sequence();
        test_seq_error();
        test_pattern_error();
        test_glitch();
        test_saturation();
        test_clear_collision();
        test_reset_mid_debounce();
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
